// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit logical shifter. A
// round-robin grant picks the requester, and a single result register
// (EMPTY/FULL) holds the shifted value until the consumer takes it.
// Results appear one cycle after acceptance. When the consumer keeps
// rsp_ready high, one result is delivered per cycle.
module shift_arbiter #(
  parameter bit PRIO_INIT = 1'b0  // requester that wins the first tie after reset
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] result_q, result_d;
  logic        id_q, id_d;
  logic        last_q;

  logic        accept, gnt0, gnt1, xfer;
  logic [31:0] sh_a;
  logic [4:0]  sh_amt;
  logic        sh_op;

  // Result slot is free (or being drained this cycle); reset blocks any handshake.
  assign accept = !rst && (state_q == EMPTY || rsp_ready);

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_q);
    gnt1 = req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = accept && gnt0;
  assign req1_ready = accept && gnt1;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Operand mux feeding the single shared shifter; gnt1 picks requester 1.
  always_comb begin
    sh_a   = gnt1 ? req1_a     : req0_a;
    sh_amt = gnt1 ? req1_shamt : req0_shamt;
    sh_op  = gnt1 ? req1_op    : req0_op;
  end

  // Logical shift, zero-fill in both directions; amount 0 passes the operand.
  always_comb begin
    result_d = sh_op ? (sh_a >> sh_amt) : (sh_a << sh_amt);
    id_d     = gnt1;
  end

  // EMPTY/FULL result-slot FSM; a drain and a new load may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      result_q <= 32'h0000_0000;
      id_q     <= 1'b0;
      last_q   <= ~PRIO_INIT;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer) begin
            state_q  <= FULL;
            result_q <= result_d;
            id_q     <= id_d;
            last_q   <= id_d;
          end
        end
        FULL: begin
          if (xfer) begin
            result_q <= result_d;
            id_q     <= id_d;
            last_q   <= id_d;
          end else if (rsp_ready) begin
            state_q  <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign busy       = (state_q == FULL);
  assign rsp_result = result_q;
  assign rsp_id     = id_q;

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_INIT, default 0, meaning the requester favoured on the first tie after reset (0 or 1).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 The block SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
REQ-006 The block SHALL have port req0_a  input  32  requester 0 operand.
REQ-007 The block SHALL have port req0_shamt  input  5  requester 0 shift amount, 0-31.
REQ-008 The block SHALL have port req0_op  input  1  requester 0 operation: 0 = logical left (SLL), 1 = logical right (SRL).
REQ-009 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_shamt and req1_op, identical to the requester 0 ports but for requester 1.
REQ-010 The block SHALL have port rsp_valid  output  1  the result register holds an undelivered result.
REQ-011 The block SHALL have port rsp_ready  input  1  the consumer takes the result this cycle.
REQ-012 The block SHALL have port rsp_result  output  32  shifted value.
REQ-013 The block SHALL have port rsp_id  output  1  index of the requester that issued the result.
REQ-014 The block SHALL have port busy  output  1  equal to rsp_valid.

Function
REQ-015 The block SHALL contain one shared combinational 32-bit logical shifter:
- Shift amount 0 SHALL pass the operand unchanged.
- Vacated bits SHALL be filled with 0 for both directions.
REQ-016 The FSM SHALL have two states:
- EMPTY: rsp_valid=0.
- FULL: rsp_valid=1.
REQ-017 The accept condition SHALL be accept = (state==EMPTY) or (state==FULL and rsp_ready=1).
REQ-018 The grant SHALL be combinational:
- Only one requester valid: that requester is granted.
- Both valid: the requester not equal to last_grant is granted.
- Neither valid: no grant.
REQ-019 reqN_ready SHALL be high only when accept=1 and requester N is granted; at most one ready SHALL be high per cycle.
REQ-020 On a transfer (reqN_valid and reqN_ready), the next edge SHALL:
- load rsp_result with the shifter output for that requester's operands;
- load rsp_id with N;
- set last_grant to N;
- enter FULL.
REQ-021 Latency SHALL be one cycle: the result is visible on rsp_* in the cycle after acceptance.
REQ-022 In FULL with rsp_ready=1 and no transfer, the block SHALL enter EMPTY.
REQ-023 In FULL with rsp_ready=1 and a simultaneous transfer, the block SHALL stay FULL with the new result loaded, giving back-to-back throughput of one result per cycle.
REQ-024 In FULL with rsp_ready=0, the block SHALL hold rsp_result and rsp_id stable, and both readies SHALL be 0.
REQ-025 last_grant SHALL change only on a transfer, so a waiting requester is served no later than the second accept opportunity (no starvation).
REQ-026 Operands SHALL be sampled only at the transfer edge; requester inputs may change freely while reqN_ready is 0.

Reset
REQ-027 While rst=1, independent of clk, the block SHALL force:
- state EMPTY, so rsp_valid=0 and busy=0;
- rsp_result = 32'h00000000;
- rsp_id = 0;
- last_grant = ~PRIO_INIT, so PRIO_INIT wins the first tie.
REQ-028 Reset asserted mid-operation SHALL discard any held result; no transfer SHALL occur while rst=1.

Verification
REQ-029 Single requester: req0 a=32'h12345678, shamt=1, op=0, rsp_ready=1 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_result=32'h2468ACF0, rsp_id=0.
REQ-030 Tie after reset, PRIO_INIT=0: both valid, req0 (a=32'hFFFFFFFF, shamt=16, op=1) and req1 (a=32'h00000001, shamt=31, op=0) -> results in order 32'h0000FFFF (id 0), then 32'h80000000 (id 1), on consecutive cycles.
REQ-031 Backpressure: FULL with rsp_ready=0 for 5 cycles while both requesters are valid -> both readies stay 0 and rsp_result/rsp_id stay constant; on the first cycle with rsp_ready=1, exactly one ready is high.
REQ-032 Continuous contention: both requesters valid for 8 cycles with rsp_ready=1 -> rsp_id alternates every cycle and 8 results are delivered.
REQ-033 Boundary values: a=32'hAAAAAAAA, shamt=31, op=1 -> 32'h00000001; a=32'h12345678, shamt=0, op=1 -> 32'h12345678.
REQ-034 Reset mid-operation: assert rst while FULL between clock edges -> rsp_valid=0 immediately; after release, a tie is won by requester PRIO_INIT.
